sdp_wdma_dfifo_sched: RTL and testbench

- Sequences the SDP write-DMA output path.
- Accepts one write command at a time and emits a header packet on the DMA write request port, then drains exactly size+1 atoms from the four per-lane data FIFOs in strict round-robin order (0→1→2→3→0).
- On the command that ends the output cube, it raises the layer-done pulse and the interrupt request.
- Sits between the WDMA command splitter, the data FIFOs and the DMA write interface.

---
 rtl/sdp_wdma_dfifo_sched.sv | 148 ++++++++++++++
 tb/tb_sdp_wdma_dfifo_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_wdma_dfifo_sched.sv
// Write-DMA output sequencer: one header packet, then size+1 atoms drained round-robin from four dfifos.
// Optional SDP_WDMA_SCHED_PERF_EN adds the dp2reg_wdma_stall counter.
//   state | meaning
//   IDLE  | waiting for a command, cmd_prdy high
//   HDR   | presenting the header packet
//   DATA  | forwarding atoms from dfifo[ptr] until beat count == size
module sdp_wdma_dfifo_sched #(
  parameter int AM_DW  = 256,
  parameter int ADDR_W = 64,
  parameter int SIZE_W = 13
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     op_load,
  input  logic                     reg2dp_interrupt_ptr,
  input  logic                     cmd_pvld,
  output logic                     cmd_prdy,
  input  logic [ADDR_W+SIZE_W:0]   cmd_pd,
  input  logic                     dfifo0_rd_pvld,
  output logic                     dfifo0_rd_prdy,
  input  logic [AM_DW-1:0]         dfifo0_rd_pd,
  input  logic                     dfifo1_rd_pvld,
  output logic                     dfifo1_rd_prdy,
  input  logic [AM_DW-1:0]         dfifo1_rd_pd,
  input  logic                     dfifo2_rd_pvld,
  output logic                     dfifo2_rd_prdy,
  input  logic [AM_DW-1:0]         dfifo2_rd_pd,
  input  logic                     dfifo3_rd_pvld,
  output logic                     dfifo3_rd_prdy,
  input  logic [AM_DW-1:0]         dfifo3_rd_pd,
  output logic                     dma_wr_req_vld,
  input  logic                     dma_wr_req_rdy,
  output logic                     dma_wr_req_type,
  output logic [AM_DW-1:0]         dma_wr_req_pd,
  output logic                     dp2reg_done,
  output logic                     intr_req_pvld,
  output logic                     intr_req_ptr
`ifdef SDP_WDMA_SCHED_PERF_EN
  , output logic [31:0]            dp2reg_wdma_stall
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [SIZE_W-1:0]   r_size;
  logic                r_cube_end;
  logic [1:0]          r_ptr;
  logic [SIZE_W-1:0]   r_cnt;
  logic                r_done;
  logic                r_intr_ptr;

  logic [3:0]          w_fifo_vld;
  logic [AM_DW-1:0]    w_fifo_pd [4];
  logic [3:0]          w_fifo_rdy;
  logic                w_xfer;
  logic                w_last;

  assign w_fifo_vld   = {dfifo3_rd_pvld, dfifo2_rd_pvld, dfifo1_rd_pvld, dfifo0_rd_pvld};
  assign w_fifo_pd[0] = dfifo0_rd_pd;
  assign w_fifo_pd[1] = dfifo1_rd_pd;
  assign w_fifo_pd[2] = dfifo2_rd_pd;
  assign w_fifo_pd[3] = dfifo3_rd_pd;

  assign dfifo0_rd_prdy = w_fifo_rdy[0];
  assign dfifo1_rd_prdy = w_fifo_rdy[1];
  assign dfifo2_rd_prdy = w_fifo_rdy[2];
  assign dfifo3_rd_prdy = w_fifo_rdy[3];

  assign w_xfer = dma_wr_req_vld & dma_wr_req_rdy;
  assign w_last = (r_cnt == r_size);

  assign dp2reg_done   = r_done;
  assign intr_req_pvld = r_done;
  assign intr_req_ptr  = r_intr_ptr;

  always_comb begin
    w_next          = r_state;
    cmd_prdy        = 1'b0;
    dma_wr_req_vld  = 1'b0;
    dma_wr_req_type = 1'b0;
    dma_wr_req_pd   = '0;
    w_fifo_rdy      = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        cmd_prdy = 1'b1;
        if (cmd_pvld) w_next = ST_HDR;
      end
      ST_HDR: begin
        dma_wr_req_vld = 1'b1;
        // cube_end lands in the require-ack bit just above size
        dma_wr_req_pd[ADDR_W+SIZE_W:0] = {r_cube_end, r_size, r_addr};
        if (dma_wr_req_rdy) w_next = ST_DATA;
      end
      ST_DATA: begin
        dma_wr_req_vld    = w_fifo_vld[r_ptr];
        dma_wr_req_type   = 1'b1;
        dma_wr_req_pd     = w_fifo_pd[r_ptr];
        w_fifo_rdy[r_ptr] = dma_wr_req_rdy;
        if (w_xfer && w_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_size     <= '0;
      r_cube_end <= 1'b0;
      r_ptr      <= 2'd0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_intr_ptr <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_DATA) && w_xfer && w_last && r_cube_end;
      if (op_load) r_intr_ptr <= reg2dp_interrupt_ptr;
      if (r_state == ST_IDLE && cmd_pvld) begin
        r_addr     <= cmd_pd[ADDR_W-1:0];
        r_size     <= cmd_pd[ADDR_W+SIZE_W-1:ADDR_W];
        r_cube_end <= cmd_pd[ADDR_W+SIZE_W];
      end
      if (r_state == ST_HDR && dma_wr_req_rdy) r_cnt <= '0;
      // op_load only rewinds the lane pointer between commands
      if (r_state == ST_DATA && w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
        r_ptr <= (w_last && r_cube_end) ? 2'd0 : r_ptr + 2'd1;
      end else if (r_state == ST_IDLE && op_load) begin
        r_ptr <= 2'd0;
      end
    end
  end

`ifdef SDP_WDMA_SCHED_PERF_EN
  logic [31:0] r_stall;
  assign dp2reg_wdma_stall = r_stall;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)                                                r_stall <= '0;
    else if (op_load)                                                    r_stall <= '0;
    else if (dma_wr_req_vld && !dma_wr_req_rdy && r_stall != 32'hFFFFFFFF) r_stall <= r_stall + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sdp_wdma_dfifo_sched.sv
// Scoreboard bench for sdp_wdma_dfifo_sched: queued expected packets from a lane/beat model, checked by a monitor.
module tb_sdp_wdma_dfifo_sched;
  localparam int AM_DW = 256, ADDR_W = 64, SIZE_W = 13, CW = ADDR_W + SIZE_W + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic op_load = 0, reg2dp_interrupt_ptr = 0, cmd_pvld = 0, cmd_prdy;
  logic [CW-1:0] cmd_pd = '0;
  logic [3:0] lane_en = 4'b0, force_lane_off = 4'b0;
  logic p0, p1, p2, p3;
  logic [AM_DW-1:0] d0, d1, d2, d3;
  logic dma_wr_req_vld, dma_wr_req_rdy = 0, dma_wr_req_type;
  logic [AM_DW-1:0] dma_wr_req_pd;
  logic dp2reg_done, intr_req_pvld, intr_req_ptr;
`ifdef SDP_WDMA_SCHED_PERF_EN
  logic [31:0] stall;
  logic [31:0] m_stall = 0;
`endif

  int unsigned rd_idx [4] = '{0, 0, 0, 0};
  logic [3:0] pend = 4'b0;
  int rdy_pct = 100, en_pct = 100;
  bit force_low = 0;

  function automatic logic [AM_DW-1:0] atom(int lane, int unsigned idx);
    logic [AM_DW-1:0] a;
    logic [31:0] h;
    h = (idx * 32'h9E3779B1) ^ (32'(lane) << 28);
    a = {8{h}};
    a[255:248] = 8'(lane);
    a[247:216] = idx;
    return a;
  endfunction

  assign d0 = atom(0, rd_idx[0]);
  assign d1 = atom(1, rd_idx[1]);
  assign d2 = atom(2, rd_idx[2]);
  assign d3 = atom(3, rd_idx[3]);

  sdp_wdma_dfifo_sched dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .op_load(op_load),
    .reg2dp_interrupt_ptr(reg2dp_interrupt_ptr), .cmd_pvld(cmd_pvld), .cmd_prdy(cmd_prdy), .cmd_pd(cmd_pd),
    .dfifo0_rd_pvld(lane_en[0]), .dfifo0_rd_prdy(p0), .dfifo0_rd_pd(d0),
    .dfifo1_rd_pvld(lane_en[1]), .dfifo1_rd_prdy(p1), .dfifo1_rd_pd(d1),
    .dfifo2_rd_pvld(lane_en[2]), .dfifo2_rd_prdy(p2), .dfifo2_rd_pd(d2),
    .dfifo3_rd_pvld(lane_en[3]), .dfifo3_rd_prdy(p3), .dfifo3_rd_pd(d3),
    .dma_wr_req_vld(dma_wr_req_vld), .dma_wr_req_rdy(dma_wr_req_rdy),
    .dma_wr_req_type(dma_wr_req_type), .dma_wr_req_pd(dma_wr_req_pd),
    .dp2reg_done(dp2reg_done), .intr_req_pvld(intr_req_pvld), .intr_req_ptr(intr_req_ptr)
`ifdef SDP_WDMA_SCHED_PERF_EN
    , .dp2reg_wdma_stall(stall)
`endif
  );

  typedef struct {
    logic             typ;
    logic [AM_DW-1:0] pd;
    int               lane;
    logic             last_cube;
  } exp_t;
  exp_t q[$];

  int m_ptr = 0;
  int unsigned m_cnt [4] = '{0, 0, 0, 0};
  logic m_intr = 0;
  logic exp_done = 0, exp_ptr = 0;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: header, then size+1 beats visiting lanes in rotation.
  task automatic push_cmd(input logic cube, input logic [SIZE_W-1:0] size, input logic [ADDR_W-1:0] addr);
    exp_t e;
    e.typ = 0; e.pd = '0; e.pd[CW-1:0] = {cube, size, addr}; e.lane = 0; e.last_cube = 0;
    q.push_back(e);
    for (int b = 0; b <= int'(size); b++) begin
      e.typ = 1; e.lane = m_ptr; e.pd = atom(m_ptr, m_cnt[m_ptr]);
      e.last_cube = cube && (b == int'(size));
      q.push_back(e);
      m_cnt[m_ptr]++;
      m_ptr = (m_ptr + 1) % 4;
    end
    if (cube) m_ptr = 0;
  endtask

  task automatic send_cmd(input logic cube, input logic [SIZE_W-1:0] size, input logic [ADDR_W-1:0] addr);
    int n = 0;
    @(posedge clk); #1;
    cmd_pvld = 1; cmd_pd = {cube, size, addr};
    forever begin
      @(negedge clk);
      if (cmd_prdy) break;
      if (++n > 20000) begin chk(0, "cmd_accept_timeout", 0, 1); break; end
    end
    @(posedge clk);
    push_cmd(cube, size, addr);
    #1 cmd_pvld = 0;
    @(negedge clk);
    chk(dma_wr_req_vld && !dma_wr_req_type, "hdr_latency", {dma_wr_req_vld, dma_wr_req_type}, 2'b10);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      if (++n > 20000) begin chk(0, "drain_timeout", q.size(), 0); q.delete(); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_op_load(input logic p);
    @(posedge clk); #1;
    op_load = 1; reg2dp_interrupt_ptr = p;
    m_intr = p;
    if (q.size() == 0) m_ptr = 0;
    @(posedge clk); #1;
    op_load = 0;
  endtask

  task automatic check_idle_outputs(input string name);
    chk(cmd_prdy && !dma_wr_req_vld && !dp2reg_done && !intr_req_pvld && !intr_req_ptr && {p3, p2, p1, p0} == 4'b0,
        name, {cmd_prdy, dma_wr_req_vld, dp2reg_done, intr_req_pvld, intr_req_ptr, p3, p2, p1, p0}, 9'h100);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 0;
    repeat (2) @(negedge clk);
    q.delete(); m_ptr = 0; m_intr = 0; pend = 4'b0;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; rd_idx[i] = 0; end
`ifdef SDP_WDMA_SCHED_PERF_EN
    m_stall = 0;
`endif
    @(posedge clk); #2;
    rst_n = 1;
    @(negedge clk);
    check_idle_outputs("post_reset_outputs");
  endtask

  // Input driver: randomized ready and FIFO availability with directed overrides.
  initial forever begin
    @(posedge clk); #1;
    dma_wr_req_rdy = !force_low && ($urandom_range(99) < rdy_pct);
    for (int i = 0; i < 4; i++) lane_en[i] = !force_lane_off[i] && ($urandom_range(99) < en_pct);
  end

  // FIFO model: pop whatever the monitor saw handshaken.
  initial forever begin
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) if (pend[i]) rd_idx[i]++;
    pend = 4'b0;
  end

  // Monitor: pops expected packets on each transfer, checks pops and completion pulses.
  initial forever begin
    logic [3:0] pops;
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin exp_done = 0; continue; end
    chk(dp2reg_done == exp_done && intr_req_pvld == exp_done && (!exp_done || intr_req_ptr == exp_ptr),
        "done_pulse", {dp2reg_done, intr_req_pvld, intr_req_ptr}, {exp_done, exp_done, exp_done & exp_ptr});
    exp_done = 0;
    pops = {p3 & lane_en[3], p2 & lane_en[2], p1 & lane_en[1], p0 & lane_en[0]};
`ifdef SDP_WDMA_SCHED_PERF_EN
    chk(stall == m_stall, "stall_count", stall, m_stall);
    if (op_load) m_stall = 0;
    else if (dma_wr_req_vld && !dma_wr_req_rdy && m_stall != 32'hFFFFFFFF) m_stall++;
`endif
    if (dma_wr_req_vld && dma_wr_req_rdy) begin
      if (q.size() == 0) begin
        chk(0, "unexpected_packet", {dma_wr_req_type, dma_wr_req_pd[255:216]}, 0);
      end else begin
        e = q.pop_front();
        chk(dma_wr_req_type == e.typ && dma_wr_req_pd == e.pd && pops == (e.typ ? 4'(1 << e.lane) : 4'b0),
            e.typ ? "data_beat" : "header",
            {dma_wr_req_type, pops, dma_wr_req_pd[255:216]}, {e.typ, (e.typ ? 4'(1 << e.lane) : 4'b0), e.pd[255:216]});
        if (e.last_cube) begin exp_done = 1; exp_ptr = m_intr; end
      end
    end else if (pops != 4'b0) begin
      chk(0, "pop_without_transfer", pops, 0);
    end
    pend = pops;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_idle_outputs("reset_outputs");

    do_op_load(1);
    send_cmd(1, 13'd3, 64'h1000);
    drain();

    send_cmd(0, 13'd2, 64'h2000);
    send_cmd(1, 13'd2, 64'h2100);
    drain();
    send_cmd(0, 13'd0, 64'h2200);
    drain();
    do_op_load(0);
    send_cmd(1, 13'd1, 64'h2300);
    drain();

    send_cmd(1, 13'd0, 64'h3000);
    drain();
    send_cmd(1, 13'd8191, 64'h4000);
    drain();

    // Stalls in header and data, an empty lane 2, and an op_load while in flight.
    force_low = 1;
    send_cmd(1, 13'd11, 64'h5000);
    repeat (10) @(negedge clk);
    force_low = 0;
    repeat (3) @(negedge clk);
    force_low = 1;
    do_op_load(1);
    repeat (10) @(negedge clk);
    force_low = 0;
    force_lane_off[2] = 1;
    repeat (5) @(negedge clk);
    force_lane_off[2] = 0;
    drain();

    for (int i = 0; i < 40; i++) begin
      rdy_pct = $urandom_range(100, 40);
      en_pct  = $urandom_range(100, 40);
      send_cmd(1'($urandom_range(1)), 13'($urandom_range(15)), {$urandom, $urandom});
      if ($urandom_range(3) == 0) begin drain(); do_op_load(1'($urandom_range(1))); end
    end
    drain();

    rdy_pct = 100; en_pct = 100;
    send_cmd(1, 13'd40, 64'h6000);
    repeat (8) @(negedge clk);
    apply_reset();
    send_cmd(1, 13'd5, 64'h7000);
    drain();

`ifdef SDP_WDMA_SCHED_PERF_EN
    do_op_load(0);
    force_low = 1;
    send_cmd(0, 13'd3, 64'h8000);
    repeat (6) @(negedge clk);
    force_low = 0;
    @(negedge clk);
    chk(stall == 32'd7, "stall_seven", stall, 7);
    drain();
    do_op_load(0);
    @(negedge clk);
    chk(stall == 32'd0, "stall_cleared", stall, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
